// File: rtl/teclado_pkg.sv
// Shared definitions for the bicycle-rack keypad scanner and wb_Teclado.
package teclado_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;

    typedef enum logic [1:0] {
        IDLE,
        DEB_PRESS,
        PRESSED,
        DEB_REL
    } scan_state_t;

    function automatic logic [3:0] key_index(
        input logic [1:0] col,
        input logic [1:0] row
    );
        return {col, row};
    endfunction

    // Legend: ASCII symbol printed on the key at index col*4+row.
    function automatic logic [7:0] key_symbol(input logic [3:0] idx);
        logic [7:0] sym;
        sym = "?";
        unique case (idx)
            4'd0:  sym = "1";
            4'd1:  sym = "4";
            4'd2:  sym = "7";
            4'd3:  sym = "*";
            4'd4:  sym = "2";
            4'd5:  sym = "5";
            4'd6:  sym = "8";
            4'd7:  sym = "0";
            4'd8:  sym = "3";
            4'd9:  sym = "6";
            4'd10: sym = "9";
            4'd11: sym = "#";
            4'd12: sym = "A";
            4'd13: sym = "B";
            4'd14: sym = "C";
            4'd15: sym = "D";
        endcase
        return sym;
    endfunction

endpackage

// File: rtl/teclado_sync.sv
// Two-flop synchronizer for the raw keypad row lines.
module teclado_sync (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] d,
    output logic [3:0] q
);

    logic [3:0] meta;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/teclado_scanner.sv
// 4x4 keypad column scanner with sweep-level debounce and ghost rejection.
import teclado_pkg::*;

module teclado_scanner #(
    parameter int SCAN_DIV = 4,
    parameter int DEBOUNCE = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] fila,
    output logic [3:0] columna,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held,
    output logic       multi_err
);

    localparam int NKEYS = NUM_ROWS * NUM_COLS;
    localparam int SW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DEB_MAX = CW'(DEBOUNCE);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [3:0]       rows;
    logic [SW-1:0]    slot;
    logic [1:0]       col;
    logic [NKEYS-1:0] snap;
    logic [NKEYS-1:0] sweep;
    logic             slot_end;
    logic             sweep_end;
    logic [4:0]       hits;
    logic [3:0]       hit_idx;
    logic             single;
    logic             multi;
    scan_state_t      state;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_inc;
    logic [3:0]       cand;

    teclado_sync u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (fila),
        .q     (rows)
    );

    assign columna   = 4'b0001 << col;
    assign slot_end  = (slot == SLOT_LAST);
    assign sweep_end = slot_end && (col == 2'd3);
    assign cnt_inc   = cnt + CNT_ONE;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slot <= '0;
            col  <= '0;
            snap <= '0;
        end else if (slot_end) begin
            slot                <= '0;
            col                 <= col + 2'd1;
            snap[{col, 2'b00} +: 4] <= rows;
        end else begin
            slot <= slot + 1'b1;
        end
    end

    // Column 3 is still being sampled on the sweep-end cycle; splice it in.
    always_comb begin
        sweep          = snap;
        sweep[12 +: 4] = rows;
    end

    always_comb begin
        hits    = '0;
        hit_idx = '0;
        for (int i = 0; i < NKEYS; i++) begin
            if (sweep[i]) begin
                hits    = hits + 5'd1;
                hit_idx = 4'(i);
            end
        end
    end

    assign single = (hits == 5'd1);
    assign multi  = (hits > 5'd1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            cand      <= '0;
            key_code  <= '0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
            multi_err <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            multi_err <= 1'b0;
            if (sweep_end) begin
                multi_err <= multi;
                unique case (state)
                    IDLE: begin
                        if (single) begin
                            cand <= hit_idx;
                            if (CNT_ONE == DEB_MAX) begin
                                state     <= PRESSED;
                                cnt       <= '0;
                                key_code  <= hit_idx;
                                key_valid <= 1'b1;
                                key_held  <= 1'b1;
                            end else begin
                                state <= DEB_PRESS;
                                cnt   <= CNT_ONE;
                            end
                        end
                    end
                    DEB_PRESS: begin
                        if (single && hit_idx == cand) begin
                            if (cnt_inc == DEB_MAX) begin
                                state     <= PRESSED;
                                cnt       <= '0;
                                key_code  <= cand;
                                key_valid <= 1'b1;
                                key_held  <= 1'b1;
                            end else begin
                                cnt <= cnt_inc;
                            end
                        end else if (single) begin
                            cand <= hit_idx;
                            cnt  <= CNT_ONE;
                        end else begin
                            state <= IDLE;
                            cnt   <= '0;
                        end
                    end
                    PRESSED: begin
                        if (!(single && hit_idx == key_code)) begin
                            if (CNT_ONE == DEB_MAX) begin
                                state    <= IDLE;
                                cnt      <= '0;
                                key_held <= 1'b0;
                            end else begin
                                state <= DEB_REL;
                                cnt   <= CNT_ONE;
                            end
                        end
                    end
                    DEB_REL: begin
                        if (single && hit_idx == key_code) begin
                            state <= PRESSED;
                            cnt   <= '0;
                        end else if (cnt_inc == DEB_MAX) begin
                            state    <= IDLE;
                            cnt      <= '0;
                            key_held <= 1'b0;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/teclado_scanner.md
# teclado_scanner

Matrix scanner and debouncer for the 4x4 bicycle-rack keypad. It sits directly upstream of wb_Teclado. It drives one-hot column strobes, samples the four row lines (the entrada1..entrada4 signals), and rejects bounce and multi-key ghosts. It emits one clean key code per physical press as a single-cycle strobe.

## Interface
- SCAN_DIV, default 4: clock cycles each column stays active. Must be 4 or more.
- DEBOUNCE, default 3: consecutive identical full sweeps needed to accept a press or a release. Must be 1 or more.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- fila  in  4  raw row inputs, active-high. fila[0] is entrada1 … fila[3] is entrada4. Asynchronous to clk.
- columna  out  4  one-hot column drive. Bit c high means column c is being scanned.
- key_code  out  4  index of the accepted key, equal to col*4+row. Held until the next accepted key.
- key_valid  out  1  single-cycle strobe: a new key_code has been accepted.
- key_held  out  1  high while the accepted key remains pressed.
- multi_err  out  1  single-cycle strobe: a sweep ended with two or more keys detected.

## Operation
- fila passes through a 2-FF synchronizer before any use.
- Slot counter counts 0..SCAN_DIV-1. Column counter counts 0..3 and wraps. columna = 1<<col.
- On the last cycle of each slot, the synchronized rows are written into snapshot bits [col*4 +: 4].
- At the end of a sweep (slot SCAN_DIV-1 of column 3), the 16-bit snapshot is classified:
  - zero bits set: NONE;
  - exactly one bit set: SINGLE(k);
  - two or more bits set: MULTI. MULTI pulses multi_err and is otherwise treated as NONE.
- FSM states: IDLE, DEB_PRESS, PRESSED, DEB_REL. The debounce counter runs 0..DEBOUNCE.
  - IDLE: on SINGLE(k), latch candidate=k, set cnt=1, go to DEB_PRESS. If DEBOUNCE=1, go straight to PRESSED and emit.
  - DEB_PRESS: on SINGLE(candidate), increment cnt. When cnt reaches DEBOUNCE, go to PRESSED, load key_code=candidate, pulse key_valid.
  - DEB_PRESS: on SINGLE(j) with j≠candidate, set candidate=j, cnt=1, stay.
  - DEB_PRESS: on NONE or MULTI, go to IDLE with cnt=0.
  - PRESSED: key_held=1. Any sweep other than SINGLE(key_code) sets cnt=1 and goes to DEB_REL.
  - DEB_REL: a non-matching sweep increments cnt. When cnt reaches DEBOUNCE, go to IDLE and drop key_held.
  - DEB_REL: SINGLE(key_code) returns to PRESSED with cnt=0. No new key_valid is emitted.
- A different key pressed while the first is still held never produces key_valid. The previous key must first pass through DEB_REL to IDLE.
- The FSM only advances at sweep ends. Between sweeps it holds its state.

## Timing
- Reset values:
  - columna=4'b0001, key_code=0, key_valid=0, key_held=0, multi_err=0;
  - FSM=IDLE, counters=0, snapshot=0, synchronizer=0.
- Reset mid-press: the FSM returns to IDLE. No key_valid is emitted until a fresh debounced press.
- Sweep length is 4*SCAN_DIV cycles.
- Synchronizer latency is 2 cycles. Sampling on the last slot cycle therefore sees rows settled for at least SCAN_DIV-3 cycles.
- Press latency, from the first clean sweep containing the key to key_valid, is DEBOUNCE sweeps.
- key_valid, key_held and multi_err are registered and update 1 cycle after the sweep-end cycle.
- key_code changes in the same cycle key_valid rises and is stable from then on.
- key_valid and multi_err never stay high for two consecutive cycles.

## Structure
- Package teclado_pkg holds:
  - FSM state encoding;
  - constants NUM_ROWS=4 and NUM_COLS=4;
  - function key_index(col,row);
  - the legend table from index to symbol (0-9, A-D, *, #), shared with wb_Teclado.
- One sub-module: teclado_sync, a 4-bit 2-FF synchronizer reset by reset.
- The counters, snapshot, classifier and FSM live in teclado_scanner.

## Test plan
All scenarios use SCAN_DIV=4, DEBOUNCE=3, so one sweep is 16 cycles.
- Reset check: hold reset=0 for 5 cycles, then release.
  - Required: columna=0001, key_valid=0, key_code=0.
  - After release, columna walks 0001→0010→0100→1000→0001, changing every 4 cycles.
- Clean press: model fila[2] high whenever columna=0010, held for 6 sweeps.
  - Required: exactly one key_valid pulse with key_code=6 (1*4+2), 3 sweeps after the first clean sweep.
  - key_held=1 until 3 sweeps after release.
- Bounce: toggle the same key present/absent on alternate sweeps for 8 sweeps.
  - Required: no key_valid.
  - Then hold it stable for 3 sweeps. Required: one key_valid with key_code=6.
- Ghost: keys 0 and 5 pressed together for 4 sweeps.
  - Required: multi_err pulses once per sweep (4 pulses), no key_valid.
- Rollover: key 3 accepted, then key 9 pressed while key 3 is still held, then key 3 released.
  - Required: no pulse for key 9 while key 3 is held.
  - After key 3 releases, key 9 alone is seen for 3 sweeps to reach IDLE, plus 3 more sweeps to debounce. key_valid then carries key_code=9.
- Reset mid-debounce: assert reset when the DEB_PRESS count is 2, then hold the key 2 sweeps after release.
  - Required: no key_valid.
  - A full 3 stable sweeps are then needed before key_valid.
